// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the control pipeline: field widths, branch
// condition encodings, per-stage control bundles and their bubble values.
package riscv_ctrl_pkg;

    localparam int RESULTSRC_W  = 2;
    localparam int ALUCONTROL_W = 4;
    localparam int FUNCT3_W     = 3;
    localparam int INSTRET_W    = 32;

    localparam logic [FUNCT3_W-1:0] F3_BEQ  = 3'b000;
    localparam logic [FUNCT3_W-1:0] F3_BNE  = 3'b001;
    localparam logic [FUNCT3_W-1:0] F3_BLT  = 3'b100;
    localparam logic [FUNCT3_W-1:0] F3_BGE  = 3'b101;
    localparam logic [FUNCT3_W-1:0] F3_BLTU = 3'b110;
    localparam logic [FUNCT3_W-1:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic                    valid;
        logic                    reg_write;
        logic                    mem_write;
        logic                    jump;
        logic                    branch;
        logic                    alu_src_b;
        logic                    pc_jal_src;
        logic [RESULTSRC_W-1:0]  result_src;
        logic [ALUCONTROL_W-1:0] alu_control;
        logic [1:0]              alu_src_a;
        logic [1:0]              write_type;
        logic [FUNCT3_W-1:0]     funct3;
    } ctrl_e_t;

    typedef struct packed {
        logic                   valid;
        logic                   reg_write;
        logic                   mem_write;
        logic [RESULTSRC_W-1:0] result_src;
        logic [1:0]             write_type;
    } ctrl_m_t;

    typedef struct packed {
        logic                   valid;
        logic                   reg_write;
        logic [RESULTSRC_W-1:0] result_src;
    } ctrl_w_t;

    // A bubble clears every control bit and the valid bit.
    localparam ctrl_e_t CTRL_E_BUBBLE = '0;
    localparam ctrl_m_t CTRL_M_BUBBLE = '0;
    localparam ctrl_w_t CTRL_W_BUBBLE = '0;

    // Branch condition from funct3 and the ALU compare flags.
    // The unused encodings 010/011 never take.
    function automatic logic branch_cond(input logic [FUNCT3_W-1:0] f3,
                                         input logic zero,
                                         input logic lt,
                                         input logic ltu);
        logic taken;
        taken = 1'b0;
        case (f3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = ~zero;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = ~lt;
            F3_BLTU: taken = ltu;
            F3_BGEU: taken = ~ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline control register: reset and flush load the bubble value,
// stall holds the current contents, otherwise the next stage bundle loads.
module ctrl_stage_reg
    import riscv_ctrl_pkg::*;
#(
    parameter int               WIDTH  = 1,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             stall,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    // Priority: reset, then flush (bubble), then stall (hold), then load.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            q_reg <= BUBBLE;
        end else if (!stall) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/control_pipe.sv
// Carries decoded controls through the E, M and W pipeline registers,
// resolves the fetch redirect in Execute and counts retired instructions.
module control_pipe
    import riscv_ctrl_pkg::*;
#(
    parameter int RESULTSRC_WIDTH  = RESULTSRC_W,
    parameter int ALUCONTROL_WIDTH = ALUCONTROL_W,
    parameter int FUNCT3_WIDTH     = FUNCT3_W,
    parameter int INSTRET_WIDTH    = INSTRET_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        Valid_D,
    input  logic                        RegWrite_D,
    input  logic                        MemWrite_D,
    input  logic                        Jump_D,
    input  logic                        Branch_D,
    input  logic                        ALUSrcB_D,
    input  logic                        PCJalSrc_D,
    input  logic [RESULTSRC_WIDTH-1:0]  ResultSrc_D,
    input  logic [ALUCONTROL_WIDTH-1:0] ALUControl_D,
    input  logic [1:0]                  ALUSrcA_D,
    input  logic [1:0]                  write_type_D,
    input  logic [FUNCT3_WIDTH-1:0]     funct3_D,
    input  logic                        Stall_E,
    input  logic                        Flush_E,
    input  logic                        Zero_E,
    input  logic                        Lt_E,
    input  logic                        Ltu_E,
    output logic [ALUCONTROL_WIDTH-1:0] ALUControl_E,
    output logic [1:0]                  ALUSrcA_E,
    output logic                        ALUSrcB_E,
    output logic                        PCJalSrc_E,
    output logic [RESULTSRC_WIDTH-1:0]  ResultSrc_E,
    output logic                        RegWrite_E,
    output logic                        PCSrc_E,
    output logic                        RegWrite_M,
    output logic                        MemWrite_M,
    output logic [RESULTSRC_WIDTH-1:0]  ResultSrc_M,
    output logic [1:0]                  write_type_M,
    output logic                        RegWrite_W,
    output logic [RESULTSRC_WIDTH-1:0]  ResultSrc_W,
    output logic [INSTRET_WIDTH-1:0]    instret
);

    // The stage bundles are laid out with the package widths, so the
    // field-width parameters must agree with them.
    if (RESULTSRC_WIDTH != RESULTSRC_W || ALUCONTROL_WIDTH != ALUCONTROL_W ||
        FUNCT3_WIDTH != FUNCT3_W) begin : g_width_check
        $error("control_pipe: field widths must match riscv_ctrl_pkg");
    end

    localparam logic [INSTRET_WIDTH-1:0] INSTRET_ONE = 1;

    ctrl_e_t e_d, e_q;
    ctrl_m_t m_d, m_q;
    ctrl_w_t w_d, w_q;
    logic    flush_m;
    logic [INSTRET_WIDTH-1:0] instret_reg;

    // Gather the decode-side controls into the E bundle.
    always_comb begin
        e_d             = CTRL_E_BUBBLE;
        e_d.valid       = Valid_D;
        e_d.reg_write   = RegWrite_D;
        e_d.mem_write   = MemWrite_D;
        e_d.jump        = Jump_D;
        e_d.branch      = Branch_D;
        e_d.alu_src_b   = ALUSrcB_D;
        e_d.pc_jal_src  = PCJalSrc_D;
        e_d.result_src  = ResultSrc_D;
        e_d.alu_control = ALUControl_D;
        e_d.alu_src_a   = ALUSrcA_D;
        e_d.write_type  = write_type_D;
        e_d.funct3      = funct3_D;
    end

    // Narrow the E bundle to what Memory and later stages still need.
    always_comb begin
        m_d            = CTRL_M_BUBBLE;
        m_d.valid      = e_q.valid;
        m_d.reg_write  = e_q.reg_write;
        m_d.mem_write  = e_q.mem_write;
        m_d.result_src = e_q.result_src;
        m_d.write_type = e_q.write_type;
    end

    // Narrow the M bundle to what Writeback needs.
    always_comb begin
        w_d            = CTRL_W_BUBBLE;
        w_d.valid      = m_q.valid;
        w_d.reg_write  = m_q.reg_write;
        w_d.result_src = m_q.result_src;
    end

    // While E holds (and is not being flushed) M must take a bubble,
    // otherwise the held instruction would advance twice.
    assign flush_m = Stall_E & ~Flush_E;

    ctrl_stage_reg #(.WIDTH($bits(ctrl_e_t)), .BUBBLE(CTRL_E_BUBBLE)) u_reg_e (
        .clk(clk), .rst(rst), .flush(Flush_E), .stall(Stall_E), .d(e_d), .q(e_q)
    );

    ctrl_stage_reg #(.WIDTH($bits(ctrl_m_t)), .BUBBLE(CTRL_M_BUBBLE)) u_reg_m (
        .clk(clk), .rst(rst), .flush(flush_m), .stall(1'b0), .d(m_d), .q(m_q)
    );

    ctrl_stage_reg #(.WIDTH($bits(ctrl_w_t)), .BUBBLE(CTRL_W_BUBBLE)) u_reg_w (
        .clk(clk), .rst(rst), .flush(1'b0), .stall(1'b0), .d(w_d), .q(w_q)
    );

    // Count each valid instruction leaving Writeback; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            instret_reg <= '0;
        end else if (w_q.valid) begin
            instret_reg <= instret_reg + INSTRET_ONE;
        end
    end

    // Redirect only for a real instruction in E.
    assign PCSrc_E = e_q.valid &
                     (e_q.jump | (e_q.branch & branch_cond(e_q.funct3, Zero_E, Lt_E, Ltu_E)));

    assign ALUControl_E = e_q.alu_control;
    assign ALUSrcA_E    = e_q.alu_src_a;
    assign ALUSrcB_E    = e_q.alu_src_b;
    assign PCJalSrc_E   = e_q.pc_jal_src;
    assign ResultSrc_E  = e_q.result_src;
    assign RegWrite_E   = e_q.reg_write;
    assign RegWrite_M   = m_q.reg_write;
    assign MemWrite_M   = m_q.mem_write;
    assign ResultSrc_M  = m_q.result_src;
    assign write_type_M = m_q.write_type;
    assign RegWrite_W   = w_q.reg_write;
    assign ResultSrc_W  = w_q.result_src;
    assign instret      = instret_reg;

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: latency, branch resolution, stall and
// flush interaction, reset discard and counter wrap (on a 4-bit instance).
module tb_control_pipe;

    logic       clk, rst;
    logic       Valid_D, RegWrite_D, MemWrite_D, Jump_D, Branch_D, ALUSrcB_D, PCJalSrc_D;
    logic [1:0] ResultSrc_D, ALUSrcA_D, write_type_D;
    logic [3:0] ALUControl_D;
    logic [2:0] funct3_D;
    logic       Stall_E, Flush_E, Zero_E, Lt_E, Ltu_E;

    logic [3:0]  ALUControl_E;
    logic [1:0]  ALUSrcA_E, ResultSrc_E, ResultSrc_M, write_type_M, ResultSrc_W;
    logic        ALUSrcB_E, PCJalSrc_E, RegWrite_E, PCSrc_E, RegWrite_M, MemWrite_M, RegWrite_W;
    logic [31:0] instret;

    logic [3:0]  s_ALUControl_E;
    logic [1:0]  s_ALUSrcA_E, s_ResultSrc_E, s_ResultSrc_M, s_write_type_M, s_ResultSrc_W;
    logic        s_ALUSrcB_E, s_PCJalSrc_E, s_RegWrite_E, s_PCSrc_E, s_RegWrite_M, s_MemWrite_M, s_RegWrite_W;
    logic [3:0]  s_instret;

    int checks = 0;
    int errors = 0;

    control_pipe dut (
        .clk(clk), .rst(rst), .Valid_D(Valid_D), .RegWrite_D(RegWrite_D), .MemWrite_D(MemWrite_D),
        .Jump_D(Jump_D), .Branch_D(Branch_D), .ALUSrcB_D(ALUSrcB_D), .PCJalSrc_D(PCJalSrc_D),
        .ResultSrc_D(ResultSrc_D), .ALUControl_D(ALUControl_D), .ALUSrcA_D(ALUSrcA_D),
        .write_type_D(write_type_D), .funct3_D(funct3_D), .Stall_E(Stall_E), .Flush_E(Flush_E),
        .Zero_E(Zero_E), .Lt_E(Lt_E), .Ltu_E(Ltu_E), .ALUControl_E(ALUControl_E),
        .ALUSrcA_E(ALUSrcA_E), .ALUSrcB_E(ALUSrcB_E), .PCJalSrc_E(PCJalSrc_E),
        .ResultSrc_E(ResultSrc_E), .RegWrite_E(RegWrite_E), .PCSrc_E(PCSrc_E),
        .RegWrite_M(RegWrite_M), .MemWrite_M(MemWrite_M), .ResultSrc_M(ResultSrc_M),
        .write_type_M(write_type_M), .RegWrite_W(RegWrite_W), .ResultSrc_W(ResultSrc_W),
        .instret(instret)
    );

    control_pipe #(.INSTRET_WIDTH(4)) dut_small (
        .clk(clk), .rst(rst), .Valid_D(Valid_D), .RegWrite_D(RegWrite_D), .MemWrite_D(MemWrite_D),
        .Jump_D(Jump_D), .Branch_D(Branch_D), .ALUSrcB_D(ALUSrcB_D), .PCJalSrc_D(PCJalSrc_D),
        .ResultSrc_D(ResultSrc_D), .ALUControl_D(ALUControl_D), .ALUSrcA_D(ALUSrcA_D),
        .write_type_D(write_type_D), .funct3_D(funct3_D), .Stall_E(Stall_E), .Flush_E(Flush_E),
        .Zero_E(Zero_E), .Lt_E(Lt_E), .Ltu_E(Ltu_E), .ALUControl_E(s_ALUControl_E),
        .ALUSrcA_E(s_ALUSrcA_E), .ALUSrcB_E(s_ALUSrcB_E), .PCJalSrc_E(s_PCJalSrc_E),
        .ResultSrc_E(s_ResultSrc_E), .RegWrite_E(s_RegWrite_E), .PCSrc_E(s_PCSrc_E),
        .RegWrite_M(s_RegWrite_M), .MemWrite_M(s_MemWrite_M), .ResultSrc_M(s_ResultSrc_M),
        .write_type_M(s_write_type_M), .RegWrite_W(s_RegWrite_W), .ResultSrc_W(s_ResultSrc_W),
        .instret(s_instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            $display("check %s observed=%0h expected=%0h ok", tag, obs, exp);
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_d(input logic v, input logic rw, input logic mw, input logic j,
                         input logic b, input logic [1:0] rs, input logic [2:0] f3,
                         input logic [1:0] wt);
        Valid_D      = v;
        RegWrite_D   = rw;
        MemWrite_D   = mw;
        Jump_D       = j;
        Branch_D     = b;
        ResultSrc_D  = rs;
        funct3_D     = f3;
        write_type_D = wt;
        ALUSrcB_D    = 1'b0;
        PCJalSrc_D   = 1'b0;
        ALUControl_D = 4'h0;
        ALUSrcA_D    = 2'b00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; Stall_E = 1'b0; Flush_E = 1'b0;
        Zero_E = 1'b0; Lt_E = 1'b0; Ltu_E = 1'b0;
        // A valid instruction at D while reset is held must not enter.
        set_d(1, 1, 1, 1, 0, 2'b11, 3'b000, 2'b11);
        tick();
        chk("rst_RegWrite_E", RegWrite_E, 0);
        chk("rst_PCSrc_E", PCSrc_E, 0);
        chk("rst_ResultSrc_E", ResultSrc_E, 0);
        chk("rst_MemWrite_M", MemWrite_M, 0);
        chk("rst_RegWrite_W", RegWrite_W, 0);
        chk("rst_instret", instret, 0);
        rst = 1'b0;

        // Latency of a single add through E, M, W and the counter.
        set_d(1, 1, 0, 0, 0, 2'b00, 3'b000, 2'b00);
        ALUControl_D = 4'ha; ALUSrcA_D = 2'b10; ALUSrcB_D = 1'b1; PCJalSrc_D = 1'b1;
        tick();
        chk("lat_RegWrite_E", RegWrite_E, 1);
        chk("lat_ALUControl_E", ALUControl_E, 4'ha);
        chk("lat_ALUSrcA_E", ALUSrcA_E, 2'b10);
        chk("lat_ALUSrcB_E", ALUSrcB_E, 1);
        chk("lat_PCJalSrc_E", PCJalSrc_E, 1);
        set_d(0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00);
        tick();
        chk("lat_RegWrite_M", RegWrite_M, 1);
        chk("lat_RegWrite_E_bubble", RegWrite_E, 0);
        tick();
        chk("lat_RegWrite_W", RegWrite_W, 1);
        chk("lat_instret_before", instret, 0);
        tick();
        chk("lat_instret_after", instret, 1);

        // Branch and jump resolution in E.
        do_reset();
        set_d(1, 0, 0, 0, 1, 2'b00, 3'b000, 2'b00);   // beq
        Zero_E = 1'b1;
        tick();
        chk("beq_zero1", PCSrc_E, 1);
        Zero_E = 1'b0; #1;
        chk("beq_zero0", PCSrc_E, 0);
        set_d(1, 0, 0, 0, 1, 2'b00, 3'b001, 2'b00);   // bne
        Zero_E = 1'b1;
        tick();
        chk("bne_zero1", PCSrc_E, 0);
        set_d(1, 0, 0, 0, 1, 2'b00, 3'b100, 2'b00);   // blt
        Zero_E = 1'b0; Lt_E = 1'b1;
        tick();
        chk("blt_lt1", PCSrc_E, 1);
        set_d(1, 0, 0, 0, 1, 2'b00, 3'b111, 2'b00);   // bgeu
        Ltu_E = 1'b0;
        tick();
        chk("bgeu_ltu0", PCSrc_E, 1);
        Ltu_E = 1'b1; #1;
        chk("bgeu_ltu1", PCSrc_E, 0);
        set_d(1, 0, 0, 0, 1, 2'b00, 3'b010, 2'b00);   // undefined branch funct3
        Zero_E = 1'b1; Lt_E = 1'b1; Ltu_E = 1'b1;
        tick();
        chk("f3_010", PCSrc_E, 0);
        set_d(1, 1, 0, 1, 0, 2'b10, 3'b000, 2'b00);   // jal
        tick();
        chk("jal", PCSrc_E, 1);
        set_d(0, 0, 0, 1, 1, 2'b00, 3'b000, 2'b00);   // not valid
        tick();
        chk("jump_invalid", PCSrc_E, 0);
        Zero_E = 1'b0; Lt_E = 1'b0; Ltu_E = 1'b0;

        // Load stalled in E for one cycle.
        do_reset();
        set_d(1, 1, 0, 0, 0, 2'b01, 3'b010, 2'b00);   // load
        tick();
        chk("stall_E_load", ResultSrc_E, 2'b01);
        set_d(1, 1, 0, 0, 0, 2'b00, 3'b000, 2'b00);   // add behind it
        Stall_E = 1'b1;
        tick();
        chk("stall_E_held", ResultSrc_E, 2'b01);
        chk("stall_M_bubble_rw", RegWrite_M, 0);
        chk("stall_M_bubble_mw", MemWrite_M, 0);
        Stall_E = 1'b0;
        tick();
        chk("stall_E_add", ResultSrc_E, 2'b00);
        chk("stall_M_load", ResultSrc_M, 2'b01);
        set_d(0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00);
        tick();
        chk("stall_W_load", ResultSrc_W, 2'b01);
        chk("stall_instret0", instret, 0);
        tick();
        chk("stall_instret1", instret, 1);
        tick();
        chk("stall_instret2", instret, 2);

        // Flush and stall together: E bubbles, M takes the old E (a store).
        do_reset();
        set_d(1, 0, 1, 0, 0, 2'b00, 3'b000, 2'b10);   // store
        tick();
        set_d(1, 1, 0, 1, 0, 2'b10, 3'b000, 2'b00);   // jal
        Flush_E = 1'b1; Stall_E = 1'b1;
        tick();
        chk("fs_PCSrc_E", PCSrc_E, 0);
        chk("fs_RegWrite_E", RegWrite_E, 0);
        chk("fs_MemWrite_M", MemWrite_M, 1);
        chk("fs_write_type_M", write_type_M, 2'b10);
        Flush_E = 1'b0; Stall_E = 1'b0;

        // Reset with three instructions in flight.
        do_reset();
        set_d(1, 1, 1, 0, 0, 2'b01, 3'b000, 2'b01);
        repeat (4) tick();
        chk("inflight_instret", instret, 1);
        rst = 1'b1;
        tick();
        chk("rstmid_RegWrite_E", RegWrite_E, 0);
        chk("rstmid_RegWrite_M", RegWrite_M, 0);
        chk("rstmid_MemWrite_M", MemWrite_M, 0);
        chk("rstmid_RegWrite_W", RegWrite_W, 0);
        chk("rstmid_instret", instret, 0);
        rst = 1'b0;
        set_d(0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00);
        tick();
        chk("rstmid_instret_next", instret, 0);

        // Counter wrap on the 4-bit instance: 16 retirements return to 0.
        do_reset();
        set_d(1, 1, 0, 0, 0, 2'b00, 3'b000, 2'b00);
        repeat (18) tick();
        chk("wrap_small_15", s_instret, 4'hf);
        chk("wrap_big_15", instret, 15);
        tick();
        chk("wrap_small_0", s_instret, 4'h0);
        chk("wrap_big_16", instret, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
